// File: rtl/control_cmd_pkg.sv
// Shared definitions for the control-stream command parsers (pixel write and
// pixel read-back): FSM state type and small width helpers.
package control_cmd_pkg;

    typedef enum logic [2:0] {
        ROW_CAPTURE    = 3'd0,
        COLUMN_CAPTURE = 3'd1,
        ISSUE_READ     = 3'd2,
        WAIT_READ      = 3'd3,
        SEND_BYTE      = 3'd4,
        DONE           = 3'd5
    } cmd_state_e;

    // Width of a field that must index n items; never narrower than one bit.
    function automatic int safe_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Number of stream bytes needed to carry a column address of the given width.
    function automatic int column_bytes(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/control_addr_capture.sv
// Captures a row byte followed by a little-endian multibyte column address
// from the control byte stream. Pulses done on the last column byte.
module control_addr_capture
    import control_cmd_pkg::*;
#(
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [7:0]          data_in,
    input  logic                clear,
    output logic [ROW_BITS-1:0] row,
    output logic [COL_BITS-1:0] column,
    output logic                done
);

    localparam int COL_BYTES = column_bytes(COL_BITS);
    localparam int CNT_W     = safe_width(COL_BYTES);
    localparam int SHIFT_W   = COL_BYTES * 8;

    logic                col_phase_q, col_phase_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [SHIFT_W-1:0]  col_shift_q, col_shift_d;

    // Bits beyond the address widths are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{data_in, col_shift_q};

    // Column bytes enter at the top and shift down, so the first byte lands in the LSB slot.
    always_comb begin
        col_phase_d = col_phase_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        col_shift_d = col_shift_q;
        done        = 1'b0;
        if (clear) begin
            col_phase_d = 1'b0;
            cnt_d       = '0;
            row_d       = '0;
            col_shift_d = '0;
        end else if (enable) begin
            if (!col_phase_q) begin
                row_d       = data_in[ROW_BITS-1:0];
                cnt_d       = CNT_W'(COL_BYTES - 1);
                col_phase_d = 1'b1;
            end else begin
                col_shift_d = (col_shift_q >> 8) | (SHIFT_W'(data_in) << (SHIFT_W - 8));
                if (cnt_q == '0) begin
                    done        = 1'b1;
                    col_phase_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    // Capture registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_phase_q <= 1'b0;
            cnt_q       <= '0;
            row_q       <= '0;
            col_shift_q <= '0;
        end else begin
            col_phase_q <= col_phase_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            col_shift_q <= col_shift_d;
        end
    end

    assign row    = row_q;
    assign column = col_shift_q[COL_BITS-1:0];

endmodule

// File: rtl/control_cmd_getpixel.sv
// Pixel read-back command: takes row and column from the control stream,
// reads each byte of the pixel from frame RAM (highest byte index first) and
// hands it to the UART transmitter over a valid/ready handshake.
module control_cmd_getpixel
    import control_cmd_pkg::*;
#(
    parameter int _NUM_ROW_ADDRESS_BITS      = 5,
    parameter int _NUM_COLUMN_ADDRESS_BITS   = 6,
    parameter int BYTES_PER_PIXEL            = 2,
    parameter int _NUM_PIXELCOLORSELECT_BITS = safe_width(BYTES_PER_PIXEL),
    parameter int RAM_READ_LATENCY           = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic [7:0]                            data_in,
    input  logic [7:0]                            ram_data_in,
    input  logic                                  tx_ready,
    output logic [_NUM_ROW_ADDRESS_BITS-1:0]      row,
    output logic [_NUM_COLUMN_ADDRESS_BITS-1:0]   column,
    output logic [_NUM_PIXELCOLORSELECT_BITS-1:0] pixel,
    output logic                                  ram_read_enable,
    output logic [7:0]                            tx_data,
    output logic                                  tx_valid,
    output logic                                  busy,
    output logic                                  done
);

    localparam int PIX_W = _NUM_PIXELCOLORSELECT_BITS;
    localparam int LAT_W = safe_width(RAM_READ_LATENCY);

    cmd_state_e       state_q, state_d;
    logic [PIX_W-1:0] pixel_q, pixel_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             cap_enable, cap_clear, cap_done;

    control_addr_capture #(
        .ROW_BITS (_NUM_ROW_ADDRESS_BITS),
        .COL_BITS (_NUM_COLUMN_ADDRESS_BITS)
    ) u_addr_capture (
        .clk     (clk),
        .reset   (reset),
        .enable  (cap_enable),
        .data_in (data_in),
        .clear   (cap_clear),
        .row     (row),
        .column  (column),
        .done    (cap_done)
    );

    // Next-state logic; stream bytes only reach the address capture in the capture states.
    always_comb begin
        state_d    = state_q;
        pixel_d    = pixel_q;
        lat_d      = lat_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        cap_enable = 1'b0;
        cap_clear  = 1'b0;
        case (state_q)
            ROW_CAPTURE: begin
                cap_enable = enable;
                if (enable) begin
                    state_d = COLUMN_CAPTURE;
                end
            end
            COLUMN_CAPTURE: begin
                cap_enable = enable;
                if (cap_done) begin
                    pixel_d = PIX_W'(BYTES_PER_PIXEL - 1);
                    state_d = ISSUE_READ;
                end
            end
            ISSUE_READ: begin
                lat_d   = LAT_W'(RAM_READ_LATENCY - 1);
                state_d = WAIT_READ;
            end
            WAIT_READ: begin
                if (lat_q == '0) begin
                    tx_data_d  = ram_data_in;
                    tx_valid_d = 1'b1;
                    state_d    = SEND_BYTE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            SEND_BYTE: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (pixel_q == '0) begin
                        state_d = DONE;
                    end else begin
                        pixel_d = pixel_q - 1'b1;
                        state_d = ISSUE_READ;
                    end
                end
            end
            DONE: begin
                cap_clear = 1'b1;
                pixel_d   = '0;
                state_d   = ROW_CAPTURE;
            end
            default: begin
                state_d = ROW_CAPTURE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ROW_CAPTURE;
            pixel_q    <= '0;
            lat_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pixel_q    <= pixel_d;
            lat_q      <= lat_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign pixel           = pixel_q;
    assign tx_data         = tx_data_q;
    assign tx_valid        = tx_valid_q;
    assign ram_read_enable = (state_q == ISSUE_READ);
    assign busy            = (state_q != ROW_CAPTURE);
    assign done            = (state_q == DONE);

endmodule

// File: tb/tb_control_cmd_getpixel.sv
// Scoreboard bench for control_cmd_getpixel: default configuration (A) and a
// wide-column, three-byte-pixel configuration (B).
`timescale 1ns/1ps
module tb_control_cmd_getpixel;

    localparam int RA = 5, CA = 6, BA = 2, PA = 1, LA = 2;
    localparam int RB = 5, CB = 9, BB = 3, PB = 2, LB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic          en_a, txr_a, rre_a, txv_a, busy_a, done_a;
    logic [7:0]    din_a, ram_a, txd_a;
    logic [RA-1:0] row_a;
    logic [CA-1:0] col_a;
    logic [PA-1:0] pix_a;

    logic          en_b, txr_b, rre_b, txv_b, busy_b, done_b;
    logic [7:0]    din_b, ram_b, txd_b;
    logic [RB-1:0] row_b;
    logic [CB-1:0] col_b;
    logic [PB-1:0] pix_b;

    control_cmd_getpixel dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .data_in(din_a), .ram_data_in(ram_a),
        .tx_ready(txr_a), .row(row_a), .column(col_a), .pixel(pix_a),
        .ram_read_enable(rre_a), .tx_data(txd_a), .tx_valid(txv_a), .busy(busy_a), .done(done_a)
    );

    control_cmd_getpixel #(
        ._NUM_COLUMN_ADDRESS_BITS(CB), .BYTES_PER_PIXEL(BB), .RAM_READ_LATENCY(LB)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .data_in(din_b), .ram_data_in(ram_b),
        .tx_ready(txr_b), .row(row_b), .column(col_b), .pixel(pix_b),
        .ram_read_enable(rre_b), .tx_data(txd_b), .tx_valid(txv_b), .busy(busy_b), .done(done_b)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference memory contents
    logic [7:0] mem_a [0:4095];
    function automatic int idx_a(input int r, input int c, input int p);
        return (r << 7) | (c << 1) | p;
    endfunction
    function automatic logic [7:0] mem_b(input int r, input int c, input int p);
        return 8'((r * 37 + c * 11 + p * 101 + 7) & 255);
    endfunction
    function automatic int enc(input int r, input int c, input int p);
        return (r << 12) | (c << 2) | p;
    endfunction

    // RAM models: data appears LAT cycles after the read pulse, inverted garbage otherwise
    logic [7:0] pa [LA];
    logic       va [LA];
    always @(posedge clk) begin
        va[0] <= rre_a;
        pa[0] <= mem_a[{row_a, col_a, pix_a}];
        for (int k = 1; k < LA; k++) begin
            va[k] <= va[k-1];
            pa[k] <= pa[k-1];
        end
    end
    assign ram_a = va[LA-1] ? pa[LA-1] : ~pa[LA-1];

    logic [7:0] pb [LB];
    logic       vb [LB];
    always @(posedge clk) begin
        vb[0] <= rre_b;
        pb[0] <= mem_b(int'(row_b), int'(col_b), int'(pix_b));
        for (int k = 1; k < LB; k++) begin
            vb[k] <= vb[k-1];
            pb[k] <= pb[k-1];
        end
    end
    assign ram_b = vb[LB-1] ? pb[LB-1] : ~pb[LB-1];

    // Scoreboard queues and counters
    int exp_tx_a[$], exp_rd_a[$], exp_tx_b[$], exp_rd_b[$];
    int exp_done_a = 0, seen_done_a = 0, exp_done_b = 0, seen_done_b = 0;

    // Monitor A
    int         cyc_a = 0, rd_cyc_a = 0, e_a;
    logic       prev_v_a = 0, prev_r_a = 0, prev_done_a = 0;
    logic [7:0] prev_d_a = 0;
    always @(negedge clk) begin
        cyc_a++;
        if (!reset) begin
            prev_v_a = 0; prev_r_a = 0; prev_done_a = 0;
        end else begin
            if (rre_a) begin
                check("a_read_while_tx_valid", int'(txv_a), 0);
                if (exp_rd_a.size() == 0) check("a_read_unexpected", 1, 0);
                else begin
                    e_a = exp_rd_a.pop_front();
                    check("a_read_addr", enc(int'(row_a), int'(col_a), int'(pix_a)), e_a);
                end
                rd_cyc_a = cyc_a;
            end
            if (txv_a && !prev_v_a) check("a_read_to_valid_cycles", cyc_a - rd_cyc_a, LA + 1);
            if (prev_v_a && !prev_r_a) begin
                check("a_tx_valid_hold", int'(txv_a), 1);
                check("a_tx_data_hold", int'(txd_a), int'(prev_d_a));
            end
            if (txv_a && txr_a) begin
                if (exp_tx_a.size() == 0) check("a_tx_unexpected", int'(txd_a), -1);
                else begin
                    e_a = exp_tx_a.pop_front();
                    check("a_tx_byte", int'(txd_a), e_a);
                end
            end
            if (done_a) begin
                seen_done_a++;
                check("a_done_one_cycle", int'(prev_done_a), 0);
            end
            prev_v_a = txv_a; prev_r_a = txr_a; prev_d_a = txd_a; prev_done_a = done_a;
        end
    end

    // Monitor B
    int cyc_b = 0, rd_cyc_b = 0, e_b;
    logic prev_v_b = 0;
    always @(negedge clk) begin
        cyc_b++;
        if (!reset) begin
            prev_v_b = 0;
        end else begin
            if (rre_b) begin
                if (exp_rd_b.size() == 0) check("b_read_unexpected", 1, 0);
                else begin
                    e_b = exp_rd_b.pop_front();
                    check("b_read_addr", enc(int'(row_b), int'(col_b), int'(pix_b)), e_b);
                end
                rd_cyc_b = cyc_b;
            end
            if (txv_b && !prev_v_b) check("b_read_to_valid_cycles", cyc_b - rd_cyc_b, LB + 1);
            if (txv_b && txr_b) begin
                if (exp_tx_b.size() == 0) check("b_tx_unexpected", int'(txd_b), -1);
                else begin
                    e_b = exp_tx_b.pop_front();
                    check("b_tx_byte", int'(txd_b), e_b);
                end
            end
            if (done_b) seen_done_b++;
            prev_v_b = txv_b;
        end
    end

    task automatic send_a(input logic [7:0] b);
        @(posedge clk); #1;
        en_a = 1'b1; din_a = b;
        @(posedge clk); #1;
        en_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        @(posedge clk); #1;
        en_b = 1'b1; din_b = b;
        @(posedge clk); #1;
        en_b = 1'b0;
    endtask

    // mode: 0 ready high, 1 random ready, 2 ready low for 10 cycles of valid
    // junk: 0 none, 1 enable every cycle, 2 random enables (all while the read is in flight)
    task automatic run_cmd_a(input logic [7:0] b0, input logic [7:0] b1, input int mode, input int junk);
        int r, c, n, low;
        bit fin;
        r = int'(b0) % 32;
        c = int'(b1) % 64;
        for (int p = BA - 1; p >= 0; p--) begin
            exp_rd_a.push_back(enc(r, c, p));
            exp_tx_a.push_back(int'(mem_a[idx_a(r, c, p)]));
        end
        exp_done_a++;
        txr_a = (mode == 2) ? 1'b0 : 1'b1;
        send_a(b0);
        send_a(b1);
        n = 0; low = 0; fin = 0;
        while (!fin && n < 300) begin
            @(posedge clk); #1;
            n++;
            en_a = 1'b0;
            check("a_row_hold", int'(row_a), r);
            check("a_col_hold", int'(col_a), c);
            if (done_a) fin = 1;
            if (junk == 1 || (junk == 2 && $urandom_range(1, 0) == 1)) begin
                en_a = 1'b1;
                din_a = 8'($urandom);
            end
            if (mode == 1) txr_a = 1'($urandom);
            else if (mode == 2) begin
                if (txv_a && low < 10) begin
                    low++;
                    txr_a = 1'b0;
                end else if (low >= 10) txr_a = 1'b1;
            end
        end
        if (!fin) check("a_done_timeout", 0, 1);
        @(posedge clk); #1;
        en_a = 1'b0;
        check("a_busy_after_done", int'(busy_a), 0);
        check("a_addr_cleared", int'({row_a, col_a, pix_a}), 0);
    endtask

    task automatic run_cmd_b;
        int n;
        bit fin;
        for (int p = BB - 1; p >= 0; p--) begin
            exp_rd_b.push_back(enc(1, 'h134, p));
            exp_tx_b.push_back(int'(mem_b(1, 'h134, p)));
        end
        exp_done_b++;
        txr_b = 1'b1;
        send_b(8'h01);
        send_b(8'h34);
        send_b(8'h01);
        n = 0; fin = 0;
        while (!fin && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (done_b) fin = 1;
        end
        if (!fin) check("b_done_timeout", 0, 1);
        @(posedge clk); #1;
        check("b_busy_after_done", int'(busy_b), 0);
        check("b_addr_cleared", int'({row_b, col_b, pix_b}), 0);
    endtask

    task automatic reset_abort_a;
        int n;
        for (int p = BA - 1; p >= 0; p--) begin
            exp_rd_a.push_back(enc(9, 'h21, p));
            exp_tx_a.push_back(int'(mem_a[idx_a(9, 'h21, p)]));
        end
        exp_done_a++;
        txr_a = 1'b0;
        send_a(8'h09);
        send_a(8'h21);
        n = 0;
        while (!txv_a && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_abort_reached_send", int'(txv_a), 1);
        #2 reset = 1'b0;
        #1;
        check("a_abort_tx_valid", int'(txv_a), 0);
        check("a_abort_read_en", int'(rre_a), 0);
        check("a_abort_busy", int'(busy_a), 0);
        check("a_abort_done", int'(done_a), 0);
        check("a_abort_regs", int'({row_a, col_a, pix_a, txd_a}), 0);
        exp_tx_a.delete();
        exp_rd_a.delete();
        exp_done_a--;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        txr_a = 1'b1;
        run_cmd_a(8'h04, 8'h10, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        en_a = 0; din_a = 0; txr_a = 1;
        en_b = 0; din_b = 0; txr_b = 1;
        for (int i = 0; i < 4096; i++) mem_a[i] = 8'($urandom);
        mem_a[idx_a(3, 'h25, 1)] = 8'hAB;
        mem_a[idx_a(3, 'h25, 0)] = 8'hCD;

        repeat (3) @(posedge clk); #1;
        check("a_reset_addr", int'({row_a, col_a, pix_a}), 0);
        check("a_reset_tx", int'({txd_a, txv_a}), 0);
        check("a_reset_ctrl", int'({rre_a, busy_a, done_a}), 0);
        check("b_reset_all", int'({row_b, col_b, pix_b, txd_b, txv_b, rre_b, busy_b, done_b}), 0);
        #2 reset = 1'b1;

        run_cmd_b();

        run_cmd_a(8'h03, 8'h25, 0, 0);
        run_cmd_a(8'h03, 8'h25, 2, 0);
        run_cmd_a(8'hFF, 8'hC5, 1, 0);
        run_cmd_a(8'h03, 8'h25, 0, 1);
        run_cmd_a(8'h01, 8'h02, 0, 0);
        reset_abort_a();
        for (int i = 0; i < 40; i++) begin
            run_cmd_a(8'($urandom), 8'($urandom), int'($urandom_range(1, 0)), 2 * int'($urandom_range(1, 0)));
        end

        repeat (10) @(posedge clk); #1;
        check("a_tx_left_over", exp_tx_a.size(), 0);
        check("a_reads_left_over", exp_rd_a.size(), 0);
        check("a_done_count", seen_done_a, exp_done_a);
        check("b_tx_left_over", exp_tx_b.size(), 0);
        check("b_reads_left_over", exp_rd_b.size(), 0);
        check("b_done_count", seen_done_b, exp_done_b);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
